// File: rtl/adc_conv_sequencer_pkg.sv
// Shared types and constants for the ADC conversion sequencer.
// Holds the FSM state encoding, synchroniser depth and default timeout.
package adc_conv_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_GAP     = 3'd4,
        ST_RECOVER = 3'd5
    } seq_state_e;

    localparam int SYNC_DEPTH      = 2;
    localparam int DEFAULT_TIMEOUT = 4095;
    localparam int RESULT_W        = 16;

endpackage

// File: rtl/adc_conv_sequencer_fifo.sv
// Synchronous result FIFO with level/full/empty status.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module adc_conv_sequencer_fifo
    import adc_conv_sequencer_pkg::*;
#(
    parameter int WIDTH = RESULT_W,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_level == LW'(DEPTH));
    assign w_empty   = (r_level == {LW{1'b0}});
    assign w_do_pop  = i_pop & ~w_empty;
    assign w_do_push = i_push & (~w_full | w_do_pop);

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_level  <= {LW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;

endmodule

// File: rtl/adc_conv_sequencer.sv
// SAR ADC front-end: issues single-shot or periodic conversions, waits for the
// macro's finished flag (with timeout) and buffers results in a small FIFO.
module adc_conv_sequencer
    import adc_conv_sequencer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD_W   = 16,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                        i_clk_dig,
    input  logic                        i_rst_n,
    input  logic                        i_enable,
    input  logic                        i_continuous,
    input  logic                        i_single_shot,
    input  logic [PERIOD_W-1:0]         i_period,
    output logic                        o_start_conversion_out,
    input  logic                        i_conversion_finished_in,
    input  logic [RESULT_W-1:0]         i_result_in,
    output logic                        o_rd_valid,
    input  logic                        i_rd_ready,
    output logic [RESULT_W-1:0]         o_rd_data,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_busy,
    output logic                        o_overflow,
    output logic                        o_timeout_err,
    input  logic                        i_err_clr
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    seq_state_e              r_state;
    logic                    r_start;
    logic                    r_busy;
    logic [TO_W-1:0]         r_to_cnt;
    logic [PERIOD_W-1:0]     r_period_cnt;
    logic [SYNC_DEPTH-1:0]   r_fin_sync;
    logic                    r_fin_prev;
    logic                    r_overflow;
    logic                    r_timeout_err;

    logic                    w_fin_rise;
    logic                    w_run_cont;
    logic                    w_to_hit;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    assign w_fin_rise = r_fin_sync[SYNC_DEPTH-1] & ~r_fin_prev;
    assign w_run_cont = i_enable & i_continuous;
    assign w_to_hit   = (r_state == ST_WAIT) & ~w_fin_rise & (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign w_push     = (r_state == ST_CAPTURE);
    assign w_pop      = i_rd_ready & ~w_fifo_empty;

    // Two-flop synchroniser for the macro's finished flag plus edge history.
    always_ff @(posedge i_clk_dig or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fin_sync <= {SYNC_DEPTH{1'b0}};
            r_fin_prev <= 1'b0;
        end else begin
            r_fin_sync <= {r_fin_sync[SYNC_DEPTH-2:0], i_conversion_finished_in};
            r_fin_prev <= r_fin_sync[SYNC_DEPTH-1];
        end
    end

    // Conversion sequencer FSM with registered start/busy and its counters.
    always_ff @(posedge i_clk_dig or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_to_cnt     <= {TO_W{1'b0}};
            r_period_cnt <= {PERIOD_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable & (i_single_shot | i_continuous)) begin
                        r_state <= ST_START;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_START: begin
                    r_to_cnt <= {TO_W{1'b0}};
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_fin_rise) begin
                        r_state <= ST_CAPTURE;
                        r_start <= 1'b0;
                    end else if (w_to_hit) begin
                        r_state <= ST_RECOVER;
                        r_start <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    // The CAPTURE cycle itself is the first low cycle of the gap.
                    if (!w_run_cont) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (i_period <= PERIOD_W'(1)) begin
                        r_state <= ST_START;
                        r_start <= 1'b1;
                    end else begin
                        r_state      <= ST_GAP;
                        r_period_cnt <= i_period - PERIOD_W'(2);
                    end
                end
                ST_GAP: begin
                    if (!w_run_cont) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_period_cnt == {PERIOD_W{1'b0}}) begin
                        r_state <= ST_START;
                        r_start <= 1'b1;
                    end else begin
                        r_period_cnt <= r_period_cnt - PERIOD_W'(1);
                    end
                end
                ST_RECOVER: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_start <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error wins over a clear in the same cycle.
    always_ff @(posedge i_clk_dig or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_overflow    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_push & w_fifo_full & ~w_pop) begin
                r_overflow <= 1'b1;
            end else if (i_err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_to_hit) begin
                r_timeout_err <= 1'b1;
            end else if (i_err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    adc_conv_sequencer_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk_dig),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (i_result_in),
        .i_pop   (w_pop),
        .o_rdata (o_rd_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (o_fifo_level)
    );

    assign o_start_conversion_out = r_start;
    assign o_busy                 = r_busy;
    assign o_rd_valid             = ~w_fifo_empty;
    assign o_overflow             = r_overflow;
    assign o_timeout_err          = r_timeout_err;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed self-checking bench for adc_conv_sequencer (FIFO depth 4, timeout 100).
module tb_adc_conv_sequencer;

    localparam int DEPTH = 4;
    localparam int PW    = 16;
    localparam int TO    = 100;

    typedef struct {
        logic [15:0] res;
        int          delay;
        logic [2:0]  exp_level;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        continuous = 1'b0;
    logic        single_shot = 1'b0;
    logic [PW-1:0] period = '0;
    logic        fin = 1'b0;
    logic [15:0] result = 16'h0000;
    logic        rd_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        start;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic [2:0]  level;
    logic        busy;
    logic        overflow;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;
    vec_t vecs [5];
    logic [15:0] drain_exp [4];

    always #5 clk = ~clk;

    adc_conv_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .PERIOD_W   (PW),
        .TIMEOUT    (TO)
    ) dut (
        .i_clk_dig                (clk),
        .i_rst_n                  (rst_n),
        .i_enable                 (enable),
        .i_continuous             (continuous),
        .i_single_shot            (single_shot),
        .i_period                 (period),
        .o_start_conversion_out   (start),
        .i_conversion_finished_in (fin),
        .i_result_in              (result),
        .o_rd_valid               (rd_valid),
        .i_rd_ready               (rd_ready),
        .o_rd_data                (rd_data),
        .o_fifo_level             (level),
        .o_busy                   (busy),
        .o_overflow               (overflow),
        .o_timeout_err            (timeout_err),
        .i_err_clr                (err_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input logic val, input int bound, input string name);
        int n;
        n = 0;
        while (start !== val && n < bound) begin
            tick();
            n++;
        end
        check(name, {31'd0, start}, {31'd0, val});
    endtask

    task automatic do_conversion(input logic [15:0] res, input int delay,
                                 input logic pop_cap, input string name);
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        check({name, " start"}, {31'd0, start}, 32'd1);
        repeat (delay) tick();
        result = res;
        fin    = 1'b1;
        wait_start(1'b0, 10, {name, " capture"});
        rd_ready = pop_cap;
        tick();
        rd_ready = 1'b0;
        check({name, " idle"}, {31'd0, busy}, 32'd0);
        fin = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low;
        vecs[0] = '{16'h0101, 3,  3'd1, 1'b0};
        vecs[1] = '{16'h0202, 7,  3'd2, 1'b0};
        vecs[2] = '{16'h0303, 1,  3'd3, 1'b0};
        vecs[3] = '{16'h0404, 12, 3'd4, 1'b0};
        vecs[4] = '{16'h0505, 4,  3'd4, 1'b1};
        drain_exp[0] = 16'h0202;
        drain_exp[1] = 16'h0303;
        drain_exp[2] = 16'h0404;
        drain_exp[3] = 16'h0606;

        // Reset state
        repeat (3) tick();
        check("reset start", {31'd0, start}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset rd_valid", {31'd0, rd_valid}, 32'd0);
        check("reset level", {29'd0, level}, 32'd0);
        check("reset flags", {30'd0, overflow, timeout_err}, 32'd0);
        rst_n = 1'b1;
        enable = 1'b1;
        tick();

        // Single shot, finished 40 cycles after start
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        check("t1 start rise", {31'd0, start}, 32'd1);
        check("t1 busy", {31'd0, busy}, 32'd1);
        repeat (40) tick();
        check("t1 start held", {31'd0, start}, 32'd1);
        check("t1 no data yet", {31'd0, rd_valid}, 32'd0);
        result = 16'h1234;
        fin    = 1'b1;
        repeat (2) tick();
        check("t1 start before fin_rise", {31'd0, start}, 32'd1);
        tick();
        check("t1 start drop", {31'd0, start}, 32'd0);
        tick();
        check("t1 rd_valid", {31'd0, rd_valid}, 32'd1);
        check("t1 rd_data", {16'd0, rd_data}, 32'h1234);
        check("t1 level", {29'd0, level}, 32'd1);
        check("t1 busy done", {31'd0, busy}, 32'd0);
        fin = 1'b0;
        repeat (3) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t1 popped level", {29'd0, level}, 32'd0);

        // Continuous mode, period 10
        period = 16'd10;
        continuous = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_start(1'b1, 40, "t2 start");
            if (k == 2) continuous = 1'b0;
            repeat (5) tick();
            result = 16'hA000 + 16'(k);
            fin    = 1'b1;
            wait_start(1'b0, 10, "t2 capture");
            fin = 1'b0;
            if (k < 2) begin
                low = 0;
                while (start == 1'b0 && low < 40) begin
                    low++;
                    tick();
                end
                check("t2 gap length", low, 32'd10);
            end
        end
        tick();
        check("t2 idle", {31'd0, busy}, 32'd0);
        check("t2 level", {29'd0, level}, 32'd3);
        for (int k = 0; k < 3; k++) begin
            check("t2 order", {16'd0, rd_data}, 32'hA000 + k);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        repeat (3) tick();

        // Overflow table, consumer stalled
        for (int i = 0; i < 5; i++) begin
            do_conversion(vecs[i].res, vecs[i].delay, 1'b0, "t3 conv");
            check("t3 level", {29'd0, level}, {29'd0, vecs[i].exp_level});
            check("t3 overflow", {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
        end
        check("t3 head kept", {16'd0, rd_data}, 32'h0101);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3 err_clr", {31'd0, overflow}, 32'd0);

        // Full FIFO, push and pop in the same cycle
        do_conversion(16'h0606, 2, 1'b1, "t4 conv");
        check("t4 level", {29'd0, level}, 32'd4);
        check("t4 no overflow", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("t4 drain data", {16'd0, rd_data}, {16'd0, drain_exp[i]});
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
        end
        check("t4 empty", {30'd0, rd_valid, level[0] | level[1] | level[2]}, 32'd0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("t4 pop empty", {29'd0, level}, 32'd0);

        // Timeout: finished never arrives
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        n = 0;
        while (start == 1'b1 && n < 300) begin
            n++;
            tick();
        end
        check("t5 start high cycles", n, 32'd101);
        check("t5 timeout_err", {31'd0, timeout_err}, 32'd1);
        tick();
        check("t5 busy", {31'd0, busy}, 32'd0);
        check("t5 no push", {29'd0, level}, 32'd0);

        // Async reset during WAIT
        do_conversion(16'h0BEE, 2, 1'b0, "t6 pre");
        check("t6 pre level", {29'd0, level}, 32'd1);
        single_shot = 1'b1;
        tick();
        single_shot = 1'b0;
        repeat (5) tick();
        check("t6 in wait", {31'd0, start}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 start async", {31'd0, start}, 32'd0);
        check("t6 level flushed", {29'd0, level}, 32'd0);
        check("t6 busy", {31'd0, busy}, 32'd0);
        check("t6 flags", {30'd0, overflow, timeout_err}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t6 idle after release", {31'd0, start | busy}, 32'd0);
        do_conversion(16'h5A5A, 4, 1'b0, "t6 post");
        check("t6 post level", {29'd0, level}, 32'd1);
        check("t6 post data", {16'd0, rd_data}, 32'h5A5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
